gray_updn_counter: RTL

Parametrised synchronous up/down Gray-code counter, the successor to the team's single-direction N-bit Gray counter. Adds runtime direction control, synchronous clear and load, a wrap or saturate mode, and a registered terminal-count flag. Intended for clock-domain-crossing pointers, position encoders and low-toggle address sequencing where consecutive outputs must differ in exactly one bit.

---
 rtl/gray_pkg.sv | 28 ++
 rtl/gray_to_bin.sv | 16 +
 rtl/gray_updn_counter.sv | 85 ++++++++
 3 files changed

// File: rtl/gray_pkg.sv
// Shared Gray-code helpers, legal width bounds and the end-of-range mode encoding.
package gray_pkg;

   localparam int unsigned GRAY_N_MIN = 2;
   localparam int unsigned GRAY_N_MAX = 32;

   typedef logic [GRAY_N_MAX-1:0] gray_word_t;

   typedef enum logic {
      MODE_WRAP = 1'b0,
      MODE_SAT  = 1'b1
   } mode_e;

   function automatic gray_word_t bin2gray(input gray_word_t b);
      return b ^ (b >> 1);
   endfunction

   // Each binary bit is the XOR of all Gray bits at or above it.
   function automatic gray_word_t gray2bin(input gray_word_t g);
      gray_word_t b;
      b = '0;
      for (int unsigned i = 0; i < GRAY_N_MAX; i++) begin
         b[i] = ^(g >> i);
      end
      return b;
   endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational prefix-XOR converter from an N-bit Gray code to binary.
module gray_to_bin #(
   parameter int N = 4
) (
   input  logic [N-1:0] gray,
   output logic [N-1:0] bin
);

   always_comb begin
      bin = '0;
      for (int unsigned i = 0; i < N; i++) begin
         bin[i] = ^(gray >> i);
      end
   end

endmodule

// File: rtl/gray_updn_counter.sv
// Up/down Gray counter with clear, load, wrap/saturate ends and a registered terminal-count flag.
// Define GRAY_UPDN_BIN_OUT_EN to add the registered binary output bin_out.
module gray_updn_counter
   import gray_pkg::*;
#(
   parameter int N        = 4,
   parameter int SATURATE = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clk_en,
   input  logic         up,
   input  logic         clear,
   input  logic         load,
   input  logic [N-1:0] load_val,
   output logic [N-1:0] gray_out,
   output logic         tc
`ifdef GRAY_UPDN_BIN_OUT_EN
   ,
   output logic [N-1:0] bin_out
`endif
);

   localparam mode_e        MODE = (SATURATE != 0) ? MODE_SAT : MODE_WRAP;
   localparam logic [N-1:0] ONE  = N'(1);

   logic [N-1:0] bin;
   logic [N-1:0] bin_next;
   logic [N-1:0] load_bin;
   logic         tc_next;
   logic         at_max;
   logic         at_min;

   gray_to_bin #(.N(N)) u_load_conv (
      .gray (load_val),
      .bin  (load_bin)
   );

   assign at_max = (bin == '1);
   assign at_min = (bin == '0);

   // A count at a boundary always flags tc; only wrap mode actually moves.
   always_comb begin
      bin_next = bin;
      tc_next  = 1'b0;
      if (clear) begin
         bin_next = '0;
      end else if (load) begin
         bin_next = load_bin;
      end else if (clk_en) begin
         if (up) begin
            if (at_max) begin
               tc_next = 1'b1;
               if (MODE == MODE_WRAP) bin_next = '0;
            end else begin
               bin_next = bin + ONE;
            end
         end else begin
            if (at_min) begin
               tc_next = 1'b1;
               if (MODE == MODE_WRAP) bin_next = '1;
            end else begin
               bin_next = bin - ONE;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bin      <= '0;
         gray_out <= '0;
         tc       <= 1'b0;
      end else begin
         bin      <= bin_next;
         gray_out <= N'(bin2gray(gray_word_t'(bin_next)));
         tc       <= tc_next;
      end
   end

`ifdef GRAY_UPDN_BIN_OUT_EN
   assign bin_out = bin;
`endif

endmodule
